// File: rtl/sata_link_rx_framer.sv
// rtl/sata_link_rx_framer.sv - SATA link-layer receive framer: primitive decode, CONT handling, frame extraction
//
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   phy_dat[31:0]     received dword, byte 0 in [7:0]
//   phy_datak[3:0]    per-byte K flags; 4'b0001 = primitive, 4'b0000 = data
//   phy_val           phy_dat/phy_datak valid this cycle
//   rx_dat[31:0]      frame dword (still scrambled), CRC dword included
//   rx_val            rx_dat valid, single-cycle per dword, no backpressure
//   rx_eop            last dword of the frame
//   prim_code[3:0]    last received primitive code (0 = unrecognised K dword)
//   prim_val          pulse: prim_code updated
//   stat_abort        pulse: frame ended by SYNC or SOF
//   stat_overlong     pulse: frame exceeded MAXLEN dwords
//   stat_code_err     pulse: unrecognised K dword

module sata_link_rx_framer #(
    parameter int MAXLEN = 2050
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] phy_dat,
    input  logic [3:0]  phy_datak,
    input  logic        phy_val,
    output logic [31:0] rx_dat,
    output logic        rx_val,
    output logic        rx_eop,
    output logic [3:0]  prim_code,
    output logic        prim_val,
    output logic        stat_abort,
    output logic        stat_overlong,
    output logic        stat_code_err
);

    // Wide enough to hold MAXLEN+1 without wrapping.
    localparam int CW = $clog2(MAXLEN + 2);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAXLEN);

    localparam logic [3:0] P_SYNC = 4'd1;
    localparam logic [3:0] P_SOF  = 4'd7;
    localparam logic [3:0] P_EOF  = 4'd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [31:0]   hold_dat, hold_dat_n;
    logic          hold_full, hold_full_n;
    logic [CW-1:0] count, count_n;
    logic          cont, cont_n;

    logic [31:0]   rx_dat_n;
    logic          rx_val_n, rx_eop_n;
    logic [3:0]    prim_code_n;
    logic          prim_val_n, stat_abort_n, stat_overlong_n, stat_code_err_n;

    logic          is_data, is_k, is_align, is_cont, dec_known;
    logic [3:0]    dec_code;

    // Primitive decode. Only datak=0001 can be a primitive; any other
    // non-zero datak pattern falls through as an unknown K dword.
    always_comb begin
        is_data   = phy_val && (phy_datak == 4'b0000);
        is_k      = phy_val && (phy_datak != 4'b0000);
        is_align  = 1'b0;
        is_cont   = 1'b0;
        dec_known = 1'b0;
        dec_code  = 4'd0;
        if (is_k && phy_datak == 4'b0001) begin
            dec_known = 1'b1;
            case (phy_dat)
                32'hB5B5957C: dec_code = 4'd1;
                32'h5757B57C: dec_code = 4'd2;
                32'h4A4A957C: dec_code = 4'd3;
                32'h5555B57C: dec_code = 4'd4;
                32'h3535B57C: dec_code = 4'd5;
                32'h5656B57C: dec_code = 4'd6;
                32'h3737B57C: dec_code = 4'd7;
                32'hD5D5B57C: dec_code = 4'd8;
                32'hD5D5AA7C: dec_code = 4'd9;
                32'h9595AA7C: dec_code = 4'd10;
                32'h5858B57C: dec_code = 4'd11;
                32'h3636B57C: dec_code = 4'd12;
                32'h9999AA7C: begin is_cont  = 1'b1; dec_known = 1'b0; end
                32'h7B4A4ABC: begin is_align = 1'b1; dec_known = 1'b0; end
                default:      dec_known = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_n         = state;
        hold_dat_n      = hold_dat;
        hold_full_n     = hold_full;
        count_n         = count;
        cont_n          = cont;
        rx_dat_n        = rx_dat;
        rx_val_n        = 1'b0;
        rx_eop_n        = 1'b0;
        prim_code_n     = prim_code;
        prim_val_n      = 1'b0;
        stat_abort_n    = 1'b0;
        stat_overlong_n = 1'b0;
        stat_code_err_n = 1'b0;

        if (is_k && !is_align) begin
            if (is_cont) begin
                // Previous primitive stays in effect; following data is junk.
                cont_n = 1'b1;
            end else begin
                cont_n     = 1'b0;
                prim_val_n = 1'b1;
                if (!dec_known) begin
                    prim_code_n     = 4'd0;
                    stat_code_err_n = 1'b1;
                end else begin
                    prim_code_n = dec_code;
                    case (state)
                        IDLE: begin
                            if (dec_code == P_SOF) begin
                                state_n     = FRAME;
                                hold_full_n = 1'b0;
                                count_n     = '0;
                            end
                        end
                        FRAME: begin
                            if (dec_code == P_EOF || dec_code == P_SYNC || dec_code == P_SOF) begin
                                // Flush whatever is held as the frame's last dword.
                                rx_val_n    = hold_full;
                                rx_eop_n    = hold_full;
                                rx_dat_n    = hold_full ? hold_dat : rx_dat;
                                hold_full_n = 1'b0;
                                count_n     = '0;
                                state_n     = (dec_code == P_SOF) ? FRAME : IDLE;
                                stat_abort_n = (dec_code != P_EOF);
                            end
                        end
                        DROP: begin
                            if (dec_code == P_EOF || dec_code == P_SYNC) begin
                                state_n = IDLE;
                            end else if (dec_code == P_SOF) begin
                                state_n     = FRAME;
                                hold_full_n = 1'b0;
                                count_n     = '0;
                            end
                        end
                        default: state_n = IDLE;
                    endcase
                end
            end
        end else if (is_data && !cont && state == FRAME) begin
            if (count == MAX_CNT) begin
                // This dword would overflow the frame: drop it, close the frame.
                rx_val_n        = hold_full;
                rx_eop_n        = hold_full;
                rx_dat_n        = hold_full ? hold_dat : rx_dat;
                hold_full_n     = 1'b0;
                stat_overlong_n = 1'b1;
                state_n         = DROP;
            end else begin
                // One-dword delay so EOF can mark the previous dword as last.
                rx_val_n    = hold_full;
                rx_dat_n    = hold_full ? hold_dat : rx_dat;
                hold_dat_n  = phy_dat;
                hold_full_n = 1'b1;
                count_n     = count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hold_dat      <= '0;
            hold_full     <= 1'b0;
            count         <= '0;
            cont          <= 1'b0;
            rx_dat        <= '0;
            rx_val        <= 1'b0;
            rx_eop        <= 1'b0;
            prim_code     <= '0;
            prim_val      <= 1'b0;
            stat_abort    <= 1'b0;
            stat_overlong <= 1'b0;
            stat_code_err <= 1'b0;
        end else begin
            state         <= state_n;
            hold_dat      <= hold_dat_n;
            hold_full     <= hold_full_n;
            count         <= count_n;
            cont          <= cont_n;
            rx_dat        <= rx_dat_n;
            rx_val        <= rx_val_n;
            rx_eop        <= rx_eop_n;
            prim_code     <= prim_code_n;
            prim_val      <= prim_val_n;
            stat_abort    <= stat_abort_n;
            stat_overlong <= stat_overlong_n;
            stat_code_err <= stat_code_err_n;
        end
    end

endmodule

// File: tb/tb_sata_link_rx_framer.sv
// tb/tb_sata_link_rx_framer.sv - directed self-checking bench for sata_link_rx_framer

module tb_sata_link_rx_framer;

    localparam logic [31:0] SYNC  = 32'hB5B5957C;
    localparam logic [31:0] SOF   = 32'h3737B57C;
    localparam logic [31:0] EOF   = 32'hD5D5B57C;
    localparam logic [31:0] HOLD  = 32'hD5D5AA7C;
    localparam logic [31:0] CONT  = 32'h9999AA7C;
    localparam logic [31:0] ALIGN = 32'h7B4A4ABC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] phy_dat;
    logic [3:0]  phy_datak;
    logic        phy_val;

    logic [31:0] rx_dat;
    logic        rx_val, rx_eop, prim_val, stat_abort, stat_overlong, stat_code_err;
    logic [3:0]  prim_code;

    logic [31:0] s_rx_dat;
    logic        s_rx_val, s_rx_eop, s_prim_val, s_stat_abort, s_stat_overlong, s_stat_code_err;
    logic [3:0]  s_prim_code;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sata_link_rx_framer dut (
        .clk(clk), .reset(reset),
        .phy_dat(phy_dat), .phy_datak(phy_datak), .phy_val(phy_val),
        .rx_dat(rx_dat), .rx_val(rx_val), .rx_eop(rx_eop),
        .prim_code(prim_code), .prim_val(prim_val),
        .stat_abort(stat_abort), .stat_overlong(stat_overlong), .stat_code_err(stat_code_err)
    );

    sata_link_rx_framer #(.MAXLEN(4)) dut4 (
        .clk(clk), .reset(reset),
        .phy_dat(phy_dat), .phy_datak(phy_datak), .phy_val(phy_val),
        .rx_dat(s_rx_dat), .rx_val(s_rx_val), .rx_eop(s_rx_eop),
        .prim_code(s_prim_code), .prim_val(s_prim_val),
        .stat_abort(s_stat_abort), .stat_overlong(s_stat_overlong), .stat_code_err(s_stat_code_err)
    );

    // Present one input cycle; return #1 after the edge that accepted it,
    // so registered outputs for that dword are visible.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic v);
        phy_dat   = d;
        phy_datak = k;
        phy_val   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic sendk(input logic [31:0] d);
        send(d, 4'b0001, 1'b1);
    endtask

    task automatic sendd(input logic [31:0] d);
        send(d, 4'b0000, 1'b1);
    endtask

    task automatic gap();
        send(32'h0, 4'b0000, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        phy_dat = '0; phy_datak = '0; phy_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rx_dat, rx_val, rx_eop, prim_code, prim_val, stat_abort, stat_overlong, stat_code_err} !== 42'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {rx_dat, rx_val, rx_eop, prim_code, prim_val, stat_abort, stat_overlong, stat_code_err});
        end
        checks++;
        if ({s_rx_dat, s_rx_val, s_rx_eop, s_prim_code, s_prim_val, s_stat_abort, s_stat_overlong, s_stat_code_err} !== 42'h0) begin
            failures++;
            $display("FAIL reset_outputs_m4 got=%h exp=0", {s_rx_dat, s_rx_val, s_rx_eop, s_prim_code, s_prim_val, s_stat_abort, s_stat_overlong, s_stat_code_err});
        end
        reset = 1'b0;
        gap();
    endtask

    task automatic test_basic_frame();
        sendk(SOF);
        checks++;
        if ({prim_val, prim_code, rx_val} !== {1'b1, 4'd7, 1'b0}) begin
            failures++; $display("FAIL basic_sof got=%b exp=%b", {prim_val, prim_code, rx_val}, {1'b1, 4'd7, 1'b0});
        end
        sendd(32'h11111111);
        checks++;
        if (rx_val !== 1'b0) begin failures++; $display("FAIL basic_d0_held got=%b exp=0", rx_val); end
        sendd(32'h22222222);
        checks++;
        if ({rx_val, rx_eop, rx_dat} !== {1'b1, 1'b0, 32'h11111111}) begin
            failures++; $display("FAIL basic_emit_d0 got=%h exp=%h", {rx_val, rx_eop, rx_dat}, {1'b1, 1'b0, 32'h11111111});
        end
        sendd(32'h33333333);
        checks++;
        if ({rx_val, rx_eop, rx_dat} !== {1'b1, 1'b0, 32'h22222222}) begin
            failures++; $display("FAIL basic_emit_d1 got=%h exp=%h", {rx_val, rx_eop, rx_dat}, {1'b1, 1'b0, 32'h22222222});
        end
        sendk(EOF);
        checks++;
        if ({rx_val, rx_eop, rx_dat, prim_val, prim_code} !== {1'b1, 1'b1, 32'h33333333, 1'b1, 4'd8}) begin
            failures++; $display("FAIL basic_eof got=%h exp=%h", {rx_val, rx_eop, rx_dat, prim_val, prim_code}, {1'b1, 1'b1, 32'h33333333, 1'b1, 4'd8});
        end
        gap();
        checks++;
        if ({rx_val, prim_val} !== 2'b00) begin failures++; $display("FAIL basic_pulse_width got=%b exp=00", {rx_val, prim_val}); end
    endtask

    task automatic test_hold_cont();
        sendk(SOF);
        sendd(32'h0000D000);
        sendk(HOLD);
        checks++;
        if ({rx_val, prim_val, prim_code} !== {1'b0, 1'b1, 4'd9}) begin
            failures++; $display("FAIL cont_hold got=%b exp=%b", {rx_val, prim_val, prim_code}, {1'b0, 1'b1, 4'd9});
        end
        sendk(CONT);
        checks++;
        if ({prim_val, prim_code} !== {1'b0, 4'd9}) begin
            failures++; $display("FAIL cont_keeps_code got=%b exp=%b", {prim_val, prim_code}, {1'b0, 4'd9});
        end
        for (int i = 0; i < 3; i++) begin
            sendd(32'hA5A5A5A5);
            checks++;
            if (rx_val !== 1'b0) begin failures++; $display("FAIL cont_junk%0d got=%b exp=0", i, rx_val); end
        end
        sendk(ALIGN);
        checks++;
        if ({rx_val, prim_val, stat_code_err} !== 3'b000) begin
            failures++; $display("FAIL cont_align got=%b exp=000", {rx_val, prim_val, stat_code_err});
        end
        sendd(32'h0000D001);
        checks++;
        if (rx_val !== 1'b0) begin failures++; $display("FAIL cont_d1_discarded got=%b exp=0", rx_val); end
        sendk(EOF);
        checks++;
        if ({rx_val, rx_eop, rx_dat, prim_code} !== {1'b1, 1'b1, 32'h0000D000, 4'd8}) begin
            failures++; $display("FAIL cont_eof got=%h exp=%h", {rx_val, rx_eop, rx_dat, prim_code}, {1'b1, 1'b1, 32'h0000D000, 4'd8});
        end
        gap();
    endtask

    task automatic test_sync_abort();
        sendk(SOF);
        sendd(32'hAAAA0000);
        sendd(32'hBBBB1111);
        checks++;
        if ({rx_val, rx_eop, rx_dat} !== {1'b1, 1'b0, 32'hAAAA0000}) begin
            failures++; $display("FAIL abort_d0 got=%h exp=%h", {rx_val, rx_eop, rx_dat}, {1'b1, 1'b0, 32'hAAAA0000});
        end
        sendk(SYNC);
        checks++;
        if ({rx_val, rx_eop, rx_dat, stat_abort, prim_code} !== {1'b1, 1'b1, 32'hBBBB1111, 1'b1, 4'd1}) begin
            failures++; $display("FAIL abort_sync got=%h exp=%h", {rx_val, rx_eop, rx_dat, stat_abort, prim_code}, {1'b1, 1'b1, 32'hBBBB1111, 1'b1, 4'd1});
        end
        gap();
        checks++;
        if ({rx_val, stat_abort} !== 2'b00) begin failures++; $display("FAIL abort_single_pulse got=%b exp=00", {rx_val, stat_abort}); end
        // Back in IDLE: data is discarded, so the second dword emits nothing.
        sendd(32'hCCCC2222);
        sendd(32'hDDDD3333);
        checks++;
        if (rx_val !== 1'b0) begin failures++; $display("FAIL abort_idle_data got=%b exp=0", rx_val); end
        gap();
    endtask

    task automatic test_overlong();
        sendk(SOF);
        sendd(32'h00000001);
        sendd(32'h00000002);
        sendd(32'h00000003);
        checks++;
        if ({s_rx_val, s_rx_eop, s_rx_dat} !== {1'b1, 1'b0, 32'h2}) begin
            failures++; $display("FAIL overlong_d2 got=%h exp=%h", {s_rx_val, s_rx_eop, s_rx_dat}, {1'b1, 1'b0, 32'h2});
        end
        sendd(32'h00000004);
        checks++;
        if ({s_rx_val, s_rx_eop, s_rx_dat, s_stat_overlong} !== {1'b1, 1'b0, 32'h3, 1'b0}) begin
            failures++; $display("FAIL overlong_d3 got=%h exp=%h", {s_rx_val, s_rx_eop, s_rx_dat, s_stat_overlong}, {1'b1, 1'b0, 32'h3, 1'b0});
        end
        sendd(32'h00000005);
        checks++;
        if ({s_rx_val, s_rx_eop, s_rx_dat, s_stat_overlong} !== {1'b1, 1'b1, 32'h4, 1'b1}) begin
            failures++; $display("FAIL overlong_trip got=%h exp=%h", {s_rx_val, s_rx_eop, s_rx_dat, s_stat_overlong}, {1'b1, 1'b1, 32'h4, 1'b1});
        end
        checks++;
        if ({rx_val, rx_eop, rx_dat, stat_overlong} !== {1'b1, 1'b0, 32'h4, 1'b0}) begin
            failures++; $display("FAIL overlong_default_d3 got=%h exp=%h", {rx_val, rx_eop, rx_dat, stat_overlong}, {1'b1, 1'b0, 32'h4, 1'b0});
        end
        sendk(EOF);
        checks++;
        if ({s_rx_val, s_stat_overlong} !== 2'b00) begin
            failures++; $display("FAIL overlong_eof_silent got=%b exp=00", {s_rx_val, s_stat_overlong});
        end
        checks++;
        if ({rx_val, rx_eop, rx_dat} !== {1'b1, 1'b1, 32'h5}) begin
            failures++; $display("FAIL overlong_default_eof got=%h exp=%h", {rx_val, rx_eop, rx_dat}, {1'b1, 1'b1, 32'h5});
        end
        gap();
    endtask

    task automatic test_code_err();
        sendk(32'h12345678);
        checks++;
        if ({prim_val, prim_code, stat_code_err, rx_val} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL code_err got=%b exp=%b", {prim_val, prim_code, stat_code_err, rx_val}, {1'b1, 4'd0, 1'b1, 1'b0});
        end
        sendk(SYNC);
        checks++;
        if ({prim_val, prim_code, stat_code_err, stat_abort} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL code_err_sync got=%b exp=%b", {prim_val, prim_code, stat_code_err, stat_abort}, {1'b1, 4'd1, 1'b0, 1'b0});
        end
        gap();
    endtask

    task automatic test_back_to_back();
        sendk(SOF);
        sendd(32'hE0E0E0E0);
        sendd(32'hE1E1E1E1);
        sendk(SOF);
        checks++;
        if ({rx_val, rx_eop, rx_dat, stat_abort} !== {1'b1, 1'b1, 32'hE1E1E1E1, 1'b1}) begin
            failures++; $display("FAIL b2b_sof_abort got=%h exp=%h", {rx_val, rx_eop, rx_dat, stat_abort}, {1'b1, 1'b1, 32'hE1E1E1E1, 1'b1});
        end
        sendd(32'hE2E2E2E2);
        checks++;
        if (rx_val !== 1'b0) begin failures++; $display("FAIL b2b_new_frame_held got=%b exp=0", rx_val); end
        sendk(EOF);
        checks++;
        if ({rx_val, rx_eop, rx_dat, stat_abort} !== {1'b1, 1'b1, 32'hE2E2E2E2, 1'b0}) begin
            failures++; $display("FAIL b2b_eof got=%h exp=%h", {rx_val, rx_eop, rx_dat, stat_abort}, {1'b1, 1'b1, 32'hE2E2E2E2, 1'b0});
        end
        gap();
    endtask

    task automatic test_reset_mid_frame();
        sendk(SOF);
        sendd(32'hF0F0F0F0);
        sendd(32'hF1F1F1F1);
        phy_val = 1'b0;
        reset = 1'b1;
        #2;
        checks++;
        if ({rx_dat, rx_val, rx_eop, prim_code, prim_val, stat_abort, stat_overlong, stat_code_err} !== 42'h0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=0", {rx_dat, rx_val, rx_eop, prim_code, prim_val, stat_abort, stat_overlong, stat_code_err});
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sendk(EOF);
        checks++;
        if ({rx_val, rx_eop, prim_val, prim_code} !== {1'b0, 1'b0, 1'b1, 4'd8}) begin
            failures++; $display("FAIL midreset_eof got=%b exp=%b", {rx_val, rx_eop, prim_val, prim_code}, {1'b0, 1'b0, 1'b1, 4'd8});
        end
        gap();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_hold_cont();
        test_sync_abort();
        test_overlong();
        test_code_err();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sata_link_rx_framer.md
SATA_LINK_RX_FRAMER -- requirements
Module: sata_link_rx_framer

Interface
REQ-001 SHALL have parameter MAXLEN, default 2050, giving the maximum number of data dwords per frame (SOF..EOF exclusive, CRC dword included).
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-004 SHALL have port phy_dat, input, 32 bits: received dword from the PHY, byte 0 in bits [7:0].
REQ-005 SHALL have port phy_datak, input, 4 bits: per-byte K-character flags.
REQ-006 SHALL have port phy_val, input, 1 bit: phy_dat/phy_datak carry a dword this cycle.
REQ-007 SHALL have port rx_dat, output, 32 bits: frame data dword (still scrambled), sent to the descrambler.
REQ-008 SHALL have port rx_val, output, 1 bit: rx_dat valid; no backpressure.
REQ-009 SHALL have port rx_eop, output, 1 bit: marks the last dword of a frame.
REQ-010 SHALL have port prim_code, output, 4 bits: last received primitive (encoding in REQ-014).
REQ-011 SHALL have port prim_val, output, 1 bit: one-cycle pulse, prim_code just updated.
REQ-012 SHALL have ports stat_abort, stat_overlong and stat_code_err, each output, 1 bit: one-cycle event pulses.

Function
REQ-013 SHALL decode a dword as a primitive only when phy_val=1 and phy_datak=4'b0001; a dword with phy_val=1 and phy_datak=0 SHALL be a data dword.
REQ-014 SHALL decode the following primitive values, each with its prim_code:
- SYNC B5B5957C=1, X_RDY 5757B57C=2, R_RDY 4A4A957C=3, R_IP 5555B57C=4
- R_OK 3535B57C=5, R_ERR 5656B57C=6, SOF 3737B57C=7, EOF D5D5B57C=8
- HOLD D5D5AA7C=9, HOLDA 9595AA7C=10, WTRM 5858B57C=11, DMAT 3636B57C=12
- CONT 9999AA7C and ALIGN 7B4A4ABC: no code
REQ-015 SHALL, for any other dword with phy_datak!=0, set prim_code=0, pulse prim_val and pulse stat_code_err.
REQ-016 SHALL ignore ALIGN completely: no state change, no pulses, CONT mode unaffected.
REQ-017 SHALL, on each coded primitive, register prim_code and pulse prim_val one cycle after acceptance.
REQ-018 SHALL, on CONT, set the cont flag and leave prim_code unchanged (the primitive before CONT remains in effect).
REQ-019 SHALL, while the cont flag is set, discard data dwords as junk; the next non-ALIGN, non-CONT primitive clears the cont flag and is processed normally.
REQ-020 SHALL implement a state machine with states IDLE, FRAME and DROP; reset state SHALL be IDLE.
REQ-021 SHALL, in IDLE, go to FRAME on SOF, with hold register empty and word count 0; data dwords received in IDLE are discarded.
REQ-022 SHALL, in FRAME, hold each data dword in a one-dword register: if the register is full it is emitted with rx_eop=0, then the new dword is loaded and the count incremented.
REQ-023 SHALL, in FRAME on EOF, emit the held dword with rx_eop=1 and go to IDLE; EOF with an empty hold register SHALL emit nothing and go to IDLE.
REQ-024 SHALL, in FRAME, stall on HOLD or on data gaps (phy_val=0) with nothing emitted and the hold register kept.
REQ-025 SHALL, in FRAME on SYNC, emit the held dword (if any) with rx_eop=1, pulse stat_abort and go to IDLE.
REQ-026 SHALL, in FRAME on SOF, treat the SOF as an abort per REQ-025 and immediately start a new frame (state FRAME, count 0).
REQ-027 SHALL, on a data dword that would make the count exceed MAXLEN, discard that dword, emit the held dword with rx_eop=1, pulse stat_overlong and go to DROP.
REQ-028 SHALL, in DROP, discard all data dwords; EOF or SYNC returns to IDLE, and SOF starts a new frame.
REQ-029 SHALL register all outputs; an emission triggered by the dword accepted in cycle N SHALL appear in cycle N+1 as a single-cycle rx_val.
REQ-030 SHALL keep the word counter wide enough to count MAXLEN+1 without wrapping.
REQ-031 SHALL recognise the other primitives (X_RDY, R_OK, WTRM, ...) while in FRAME; these SHALL update prim_code only, with no frame action.

Reset
REQ-032 SHALL, on reset, clear rx_dat, rx_val, rx_eop, prim_code, prim_val and all stat_* outputs to 0, empty the hold register, clear the cont flag and zero the counter.
REQ-033 SHALL discard any partial frame on reset mid-frame; after reset release, no rx_eop is emitted for that frame.

Verification
REQ-034 Bench SHALL cover: SOF, D0=11111111, D1=22222222, C=33333333, EOF -> rx_val pulses carrying 11111111, 22222222, then 33333333 with rx_eop=1; prim_code goes 7 then 8.
REQ-035 Bench SHALL cover: SOF, D0, HOLD, CONT, junk A5A5A5A5 x3, ALIGN, D1, EOF -> junk is not emitted, and neither is D1 (cont is still set because ALIGN does not clear it); D0 is emitted with rx_eop=1 on EOF.
REQ-036 Bench SHALL cover: SOF, D0, D1, SYNC -> D0 emitted (eop=0), D1 emitted (eop=1), stat_abort pulses once; state returns to IDLE.
REQ-037 Bench SHALL cover: MAXLEN=4; SOF, 5 data dwords, EOF -> first 3 dwords emitted, then the 4th emitted with eop=1 and stat_overlong pulses; the 5th dword and EOF produce no rx_val.
REQ-038 Bench SHALL cover: dword 12345678 with datak=0001 -> prim_code=0, stat_code_err pulses; a following SYNC -> prim_code=1.
REQ-039 Bench SHALL cover: reset asserted after SOF, D0, D1 -> all outputs 0; after release, an EOF produces no rx_val.
